serial_sub32: RTL and testbench
===============================

Name: serial_sub32

Overview:
- Multi-cycle 32-bit subtractor, diff = a - b. It is the inverse operation of the team's 32-bit ripple-carry adder.
- Computes one 4-bit digit per clock through a single reused RCA4 slice, using two's-complement add: a + ~b + 1.
- Sits beside the adder datapath as an area-minimal ALU subtract unit, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; fixed to match the RCA4 slice.
- STEPS, WIDTH/DIGIT (8), derived count of digit cycles; not overridable.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands a and b are valid.
- in_ready  output  1  unit can accept operands (high only in IDLE).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result is valid (high only in DONE).
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b, modulo 2^WIDTH.
- borrow_out  output  1  1 when unsigned a < b (equals the inverted final carry).
- overflow  output  1  signed two's-complement overflow of a - b.

Behaviour:
- Reset, synchronous, on any clk edge with rst=1:
  - state goes to IDLE, the digit counter to 0, and the carry register to 1.
  - diff, borrow_out, overflow and out_valid all go to 0; in_ready goes to 1 in the following cycle.
  - rst overrides every other input and aborts any operation in progress; no partial result is ever presented.
- FSM states IDLE, RUN, DONE. Outputs are registered or derived from state only; no combinational path from inputs to outputs.
- IDLE: in_ready=1, out_valid=0.
  - Accept on an edge where in_valid && in_ready.
  - On accept, latch a into opA, latch ~b into opB, latch the sign bits a[WIDTH-1] and b[WIDTH-1], set carry=1, set count=0, clear the diff register, then go to RUN.
- RUN: in_ready=0, out_valid=0. Each cycle:
  - the RCA4 slice adds opA[3:0] + opB[3:0] + carry.
  - the slice's sum is shifted into diff from the MSB side: diff <= {sum4, diff[WIDTH-1:4]}.
  - opA and opB shift right by DIGIT, the slice's c_out is stored into carry, and count increments.
- RUN to DONE: on the edge where count == STEPS-1 (the 8th RUN cycle).
  - On that edge, borrow_out <= ~c_out of the final digit.
  - On that edge, overflow <= (signA != signB) && (diff[WIDTH-1] after final shift != signA).
- DONE: out_valid=1; diff, borrow_out and overflow are held stable.
  - On an edge where out_ready=1, go to IDLE.
  - out_valid drops in the next cycle; diff, borrow_out and overflow keep their last values until the next accept.
- Latency: out_valid rises exactly STEPS+1 = 9 cycles after the accept edge. Minimum initiation interval is 10 cycles (accept, 8 RUN cycles, 1 DONE cycle with out_ready=1).
- Boundaries:
  - in_valid while busy is ignored; the source must hold it.
  - out_ready held high during RUN has no effect.
  - out_ready=0 in DONE stalls the unit indefinitely with the result stable.
  - Operand changes after the accept edge do not affect the result.
  - Arithmetic wraps modulo 2^32; borrow_out and overflow are independent flags.
  - Simultaneous rst and in_valid: reset wins and no accept occurs.

Decomposition:
- Shared package alu_pkg: WIDTH and DIGIT constants, the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), and a STEPS function.
- Single natural sub-module: the existing RCA4 (4-bit ripple-carry slice), instantiated once.
- Control FSM, counter, and shift registers live in serial_sub32 itself.

Test Plan:
- a=5, b=3, out_ready=1 -> diff=0x00000002, borrow_out=0, overflow=0; out_valid rises exactly 9 cycles after the accept.
- a=3, b=5 -> diff=0xFFFFFFFE, borrow_out=1, overflow=0.
- a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, borrow_out=0, overflow=1. Also a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, borrow_out=1, overflow=1.
- Backpressure: a=0x12345678, b=0x02345678 with out_ready=0 for 20 cycles -> out_valid stays 1 and diff=0x10000000 stays stable; in_ready=0 throughout and a second in_valid pulse is ignored; raise out_ready -> IDLE and in_ready=1 one cycle later.
- Reset mid-operation: assert rst for 1 cycle in the 4th RUN cycle -> next cycle out_valid=0, diff=0, in_ready=1; a new a=10, b=10 gives diff=0, borrow_out=0, overflow=0.
- Back-to-back: 16 random operand pairs with out_ready=1 and in_valid held high -> each result matches a-b modulo 2^32 and both flags match the golden model; accepts are spaced 10 cycles apart.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, control-state encoding and a step-count helper
// used by the serial arithmetic units.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit cycles needed to cover a word; width must divide evenly.
  function automatic int steps(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/serial_sub32_rca4.sv
// 4-bit ripple-carry slice shared by the serial adder and subtractor datapaths.
module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[4];

endmodule

// File: rtl/serial_sub32.sv
// Area-minimal serial subtractor: diff = a - b computed one digit per clock as a + ~b + 1
// through a single reused rca4 slice, with valid/ready handshakes on both sides.
module serial_sub32
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int DIGIT = alu_pkg::DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int STEPS = steps(WIDTH, DIGIT);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             overflow_r;

  logic [DIGIT-1:0] sum4;
  logic             c_out;

  rca4 u_slice (
    .a    (op_a[DIGIT-1:0]),
    .b    (op_b[DIGIT-1:0]),
    .c_in (carry),
    .sum  (sum4),
    .c_out(c_out)
  );

  // Handshake outputs depend on the registered state only.
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign diff       = diff_r;
  assign borrow_out = borrow_r;
  assign overflow   = overflow_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      carry      <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      diff_r     <= '0;
      borrow_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a   <= a;
            op_b   <= ~b;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            carry  <= 1'b1;
            count  <= '0;
            diff_r <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          // Low digit first; each new digit enters at the top so the word lands aligned.
          diff_r <= {sum4, diff_r[WIDTH-1:DIGIT]};
          op_a   <= op_a >> DIGIT;
          op_b   <= op_b >> DIGIT;
          carry  <= c_out;
          count  <= count + 1'b1;
          if (count == LAST) begin
            borrow_r   <= ~c_out;
            overflow_r <= (sign_a != sign_b) && (sum4[DIGIT-1] != sign_a);
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub32.sv
// Randomized scoreboard bench for serial_sub32: accepts push golden results computed with
// plain arithmetic, a negedge monitor pops and compares whenever a result is handed over.
module tb_serial_sub32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow_out;
  logic        overflow;

  serial_sub32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow_out(borrow_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        br;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accepts = 0;
  int   last_acc = -1;
  bit   btb = 1'b0;
  bit   prev_ov = 1'b0;

  always @(posedge clk) cyc++;

  // Golden model: plain unsigned/signed arithmetic on the operands.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int acc);
    exp_t   e;
    longint sx;
    longint sy;
    longint r;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    r     = sx - sy;
    e.d   = x - y;
    e.br  = (x < y);
    e.ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.acc = acc;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: scoreboard pops on output handshakes, pushes on input handshakes.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          checkOutput("latency", 64'(cyc + 1 - exp_q[0].acc), 64'd9);
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("diff", 64'(diff), 64'(e.d));
        checkOutput("borrow_out", 64'(borrow_out), 64'(e.br));
        checkOutput("overflow", 64'(overflow), 64'(e.ov));
      end
      prev_ov = out_valid;
      if (in_valid && in_ready) begin
        if (btb && last_acc >= 0) checkOutput("accept_spacing", 64'(cyc + 1 - last_acc), 64'd10);
        last_acc = cyc + 1;
        exp_q.push_back(model(a, b, cyc + 1));
        accepts++;
      end
    end
  end

  task automatic waitAccept();
    int start = accepts;
    int k = 0;
    while (accepts == start && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (accepts == start) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got no accept expected one within 50 cycles");
    end
  endtask

  task automatic waitDrain();
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, then scramble the operand pins to show they are not reused.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    waitAccept();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
  endtask

  initial begin
    #200000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_diff", 64'(diff), 64'd0);
    checkOutput("reset_borrow", 64'(borrow_out), 64'd0);
    checkOutput("reset_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] directed corner operands");
    applyStimulus(32'd5, 32'd3);                  waitDrain();
    applyStimulus(32'd3, 32'd5);                  waitDrain();
    applyStimulus(32'h8000_0000, 32'h0000_0001);  waitDrain();
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF);  waitDrain();

    $display("[TB] backpressure stall");
    out_ready = 1'b0;
    applyStimulus(32'h1234_5678, 32'h0234_5678);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) begin
        in_valid = 1'b1;
        a        = $urandom;
        b        = $urandom;
      end
      if (i == 6) in_valid = 1'b0;
      @(negedge clk);
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_diff", 64'(diff), 64'h1000_0000);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("release_out_valid", 64'(out_valid), 64'd0);
    checkOutput("release_diff_held", 64'(diff), 64'h1000_0000);

    $display("[TB] reset during RUN");
    @(posedge clk);
    #1;
    a        = $urandom;
    b        = $urandom;
    in_valid = 1'b1;
    waitAccept();
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_diff", 64'(diff), 64'd0);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_borrow", 64'(borrow_out), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(32'd10, 32'd10);
    waitDrain();

    $display("[TB] reset coinciding with in_valid");
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 32'd7;
    b        = 32'd3;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_vs_valid_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_vs_valid_out_valid", 64'(out_valid), 64'd0);
    repeat (12) @(posedge clk);
    #1;

    $display("[TB] back-to-back random operands");
    last_acc  = -1;
    btb       = 1'b1;
    out_ready = 1'b1;
    a         = $urandom;
    b         = $urandom;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      waitAccept();
      if (i == 15) in_valid = 1'b0;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    end
    waitDrain();
    btb = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
